// File: rtl/yarp_mem_arbiter.sv
// Arbitrates YARP's single memory port between instruction fetch and load/store,
// with data priority and a streak counter that bounds fetch starvation.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate and capture the winner's request
// ISSUE | mem_req_o asserted with stable payload, waiting for mem_gnt_i
// RESP  | request accepted, waiting for mem_rvalid_i to route to owner
module yarp_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    input  logic              data_req_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_byte_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [1:0]        mem_byte_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [1:0] BYTE_WORD  = 2'b11;

    state_t     state_q, state_d;
    logic       owner_data_q;
    logic [3:0] streak_q;
    logic       fetch_pick;
    logic       data_pick;

    // Fetch wins when alone, or when data has held the port for a full streak.
    assign fetch_pick = instr_req_i && (!data_req_i || (streak_q == STREAK_MAX));
    assign data_pick  = data_req_i && !fetch_pick;

    always_comb begin
        state_d        = state_q;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        mem_req_o      = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are combinational, so keep them quiet while reset is held.
                instr_gnt_o = fetch_pick && reset_n;
                data_gnt_o  = data_pick && reset_n;
                if (fetch_pick || data_pick) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    instr_rvalid_o = !owner_data_q;
                    data_rvalid_o  = owner_data_q;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            streak_q     <= 4'd0;
            mem_addr_o   <= '0;
            mem_wr_o     <= 1'b0;
            mem_byte_o   <= 2'b00;
            mem_wdata_o  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && fetch_pick) begin
                owner_data_q <= 1'b0;
                streak_q     <= 4'd0;
                mem_addr_o   <= instr_addr_i;
                mem_wr_o     <= 1'b0;
                mem_byte_o   <= BYTE_WORD;
                mem_wdata_o  <= '0;
            end else if (state_q == IDLE && data_pick) begin
                owner_data_q <= 1'b1;
                if (!instr_req_i) begin
                    streak_q <= 4'd0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + 4'd1;
                end
                mem_addr_o  <= data_addr_i;
                mem_wr_o    <= data_wr_i;
                mem_byte_o  <= data_byte_i;
                mem_wdata_o <= data_wdata_i;
            end
        end
    end

endmodule
